// File: rtl/pipe_stage_reg_if.sv
// Stage-boundary bundle for pipe_stage_reg: control, upstream slot and registered downstream slot.
// Counter signals exist only when PIPE_STAGE_PERF_EN is defined.
interface pipe_stage_reg_if #(
  parameter int DATA_W    = 32,
  parameter int NUM_WORDS = 3,
  parameter int EXC_W     = 5,
  parameter int CNT_W     = 16
);
  logic                          flush;
  logic                          stall;
  logic                          valid_in;
  logic [31:0]                   ir_in;
  logic [31:0]                   pc_in;
  logic [DATA_W*NUM_WORDS-1:0]   data_in;
  logic                          brdelay_in;
  logic [EXC_W-1:0]              exc_now_in;
  logic [EXC_W-1:0]              exc_pre_in;

  logic                          valid_out;
  logic [31:0]                   ir_out;
  logic [31:0]                   pc_out;
  logic [31:0]                   pc4_out;
  logic [31:0]                   pc8_out;
  logic [DATA_W*NUM_WORDS-1:0]   data_out;
  logic                          brdelay_out;
  logic [EXC_W-1:0]              exc_out;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]              stall_cnt;
  logic [CNT_W-1:0]              bubble_cnt;

  modport master (
    output flush, stall, valid_in, ir_in, pc_in, data_in, brdelay_in, exc_now_in, exc_pre_in,
    input  valid_out, ir_out, pc_out, pc4_out, pc8_out, data_out, brdelay_out, exc_out,
    input  stall_cnt, bubble_cnt
  );

  modport slave (
    input  flush, stall, valid_in, ir_in, pc_in, data_in, brdelay_in, exc_now_in, exc_pre_in,
    output valid_out, ir_out, pc_out, pc4_out, pc8_out, data_out, brdelay_out, exc_out,
    output stall_cnt, bubble_cnt
  );
`else
  modport master (
    output flush, stall, valid_in, ir_in, pc_in, data_in, brdelay_in, exc_now_in, exc_pre_in,
    input  valid_out, ir_out, pc_out, pc4_out, pc8_out, data_out, brdelay_out, exc_out
  );

  modport slave (
    input  flush, stall, valid_in, ir_in, pc_in, data_in, brdelay_in, exc_now_in, exc_pre_in,
    output valid_out, ir_out, pc_out, pc4_out, pc8_out, data_out, brdelay_out, exc_out
  );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/flush, exception merge and PC+4/PC+8.
// Optional perf counters (stall_cnt, bubble_cnt) enabled by PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int          DATA_W    = 32,
  parameter int          NUM_WORDS = 3,
  parameter int          EXC_W     = 5,
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int          CNT_W     = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_reg_if.slave  bus
);

  localparam int PW = DATA_W * NUM_WORDS;

  typedef enum logic [1:0] {
    SEL_HOLD   = 2'd0,
    SEL_BUBBLE = 2'd1,
    SEL_LOAD   = 2'd2
  } sel_e;

  // The stage's own exception wins over the one inherited from earlier stages.
  function automatic logic [EXC_W-1:0] merge_exc(input logic [EXC_W-1:0] now_v,
                                                 input logic [EXC_W-1:0] pre_v);
    merge_exc = (now_v != {EXC_W{1'b0}}) ? now_v : pre_v;
  endfunction

  sel_e              sel_s;
  logic              valid_q,   valid_d;
  logic [31:0]       ir_q,      ir_d;
  logic [31:0]       pc_q,      pc_d;
  logic [PW-1:0]     data_q,    data_d;
  logic              brdelay_q, brdelay_d;
  logic [EXC_W-1:0]  exc_q,     exc_d;

  always_comb begin
    sel_s = SEL_HOLD;
    if (reset || bus.flush) begin
      sel_s = SEL_BUBBLE;
    end else if (bus.stall) begin
      sel_s = SEL_HOLD;
    end else if (bus.valid_in) begin
      sel_s = SEL_LOAD;
    end else begin
      sel_s = SEL_BUBBLE;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    ir_d      = ir_q;
    pc_d      = pc_q;
    data_d    = data_q;
    brdelay_d = brdelay_q;
    exc_d     = exc_q;
    case (sel_s)
      SEL_BUBBLE: begin
        valid_d   = 1'b0;
        ir_d      = 32'h0000_0000;
        pc_d      = PC_RESET;
        data_d    = {PW{1'b0}};
        brdelay_d = 1'b0;
        exc_d     = {EXC_W{1'b0}};
      end
      SEL_LOAD: begin
        valid_d   = 1'b1;
        ir_d      = bus.ir_in;
        pc_d      = bus.pc_in;
        data_d    = bus.data_in;
        brdelay_d = bus.brdelay_in;
        exc_d     = merge_exc(bus.exc_now_in, bus.exc_pre_in);
      end
      SEL_HOLD: begin
        valid_d   = valid_q;
      end
      default: begin
        valid_d   = 1'b0;
        ir_d      = 32'h0000_0000;
        pc_d      = PC_RESET;
        data_d    = {PW{1'b0}};
        brdelay_d = 1'b0;
        exc_d     = {EXC_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    valid_q   <= valid_d;
    ir_q      <= ir_d;
    pc_q      <= pc_d;
    data_q    <= data_d;
    brdelay_q <= brdelay_d;
    exc_q     <= exc_d;
  end

  assign bus.valid_out   = valid_q;
  assign bus.ir_out      = ir_q;
  assign bus.pc_out      = pc_q;
  assign bus.pc4_out     = pc_q + 32'd4;
  assign bus.pc8_out     = pc_q + 32'd8;
  assign bus.data_out    = data_q;
  assign bus.brdelay_out = brdelay_q;
  assign bus.exc_out     = exc_q;

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             stall_inc_s;
  logic             bubble_inc_s;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Reset-driven bubbles are not counted; only flush and empty upstream slots.
  assign stall_inc_s  = !reset && !bus.flush && bus.stall;
  assign bubble_inc_s = !reset && (bus.flush || (!bus.stall && !bus.valid_in));

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (reset) begin
      stall_cnt_d  = {CNT_W{1'b0}};
      bubble_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (bubble_inc_s && (bubble_cnt_q != CNT_MAX)) begin
        bubble_cnt_d = bubble_cnt_q + CNT_ONE;
      end else begin
        bubble_cnt_d = bubble_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    stall_cnt_q  <= stall_cnt_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule
